mem_arbiter: RTL and testbench

- Shares the single RAM controller port between two requesters: the instruction fetch port (reads only, including prefetch) and the data port from the memory-access stage (loads and stores).
- Sits between the core (fetch unit and memory stage) and the RAM controller / paging logic.
- Data port has priority; a starvation counter guarantees forward progress for fetch.
- Presents each requester the same cmd/cack/data_ready/busy handshake the RAM controller exposes, so requesters need no change.

---
 rtl/pcpu_mem_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   arb_state_t : arbiter sequencing states (IDLE, CMD, WAIT)
//   owner_t     : which requester owns the downstream port (NONE, FETCH, DATA)
//   OWNER_W     : encoded width of owner_t
//   STREAK_W    : width of the data-grant streak counter
//   STREAK_MAX  : saturation value of the streak counter
package pcpu_mem_pkg;

    localparam int OWNER_W  = 2;
    localparam int STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [OWNER_W-1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority/fairness selector for the memory arbiter.
// Data normally wins; fetch is forced once data has been granted
// MAX_D_STREAK times in a row while fetch was waiting.
//   f_req      in  fetch request present
//   d_req      in  data request present (read or write)
//   streak     in  consecutive data grants made while fetch was pending
//   owner_next out requester that would be granted now (NONE if no request)
import pcpu_mem_pkg::*;

module mem_arb_pick #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                f_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output owner_t              owner_next
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_D_STREAK);

    always_comb begin
        owner_next = NONE;
        if (f_req && (!d_req || streak >= STREAK_LIMIT)) begin
            owner_next = FETCH;
        end else if (d_req) begin
            owner_next = DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the RAM controller. The fetch port (reads)
// and the data port (loads/stores) each see the controller's own
// cmd/cack/data_ready/busy handshake. One transaction is outstanding at a
// time; data has priority, with a streak counter guaranteeing fetch progress.
//   clk, rst (async, active-low)
//   f_read/f_addr       -> f_cack, f_data_ready, f_busy, f_data[31:0]
//   d_read/d_write/d_addr/d_wdata -> d_cack, d_data_ready, d_busy, d_data[15:0]
//   mem_read/mem_write/mem_addr/mem_wdata (registered command to controller)
//   mem_cack, mem_data_ready, mem_busy, mem_rdata[31:0] (controller responses)
import pcpu_mem_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_read,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_cack,
    output logic              f_data_ready,
    output logic              f_busy,
    output logic [31:0]       f_data,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_cack,
    output logic              d_data_ready,
    output logic              d_busy,
    output logic [15:0]       d_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_cack,
    input  logic              mem_data_ready,
    input  logic              mem_busy,
    input  logic [31:0]       mem_rdata
);

    arb_state_t          state, state_nx;
    owner_t              owner, owner_nx, pick_owner;
    logic [STREAK_W-1:0] streak, streak_nx;
    logic                read_nx, write_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [15:0]         wdata_nx;
    logic                d_req;
    logic                owner_req;

    assign d_req = d_read | d_write;

    mem_arb_pick #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_pick (
        .f_req     (f_read),
        .d_req     (d_req),
        .streak    (streak),
        .owner_next(pick_owner)
    );

    // Whether the current owner is still asking; a withdrawal in CMD cancels.
    always_comb begin
        owner_req = 1'b0;
        case (owner)
            FETCH:   owner_req = f_read;
            DATA:    owner_req = d_req;
            default: owner_req = 1'b0;
        endcase
    end

    // Next-state logic; the downstream command is registered so it rises
    // one cycle after the request is sampled in IDLE.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        streak_nx = streak;
        read_nx   = mem_read;
        write_nx  = mem_write;
        addr_nx   = mem_addr;
        wdata_nx  = mem_wdata;
        case (state)
            IDLE: begin
                if (!mem_busy && pick_owner != NONE) begin
                    state_nx = CMD;
                    owner_nx = pick_owner;
                    if (pick_owner == FETCH) begin
                        read_nx   = 1'b1;
                        write_nx  = 1'b0;
                        addr_nx   = f_addr;
                        wdata_nx  = '0;
                        streak_nx = '0;
                    end else begin
                        read_nx  = d_read;
                        write_nx = d_write;
                        addr_nx  = d_addr;
                        wdata_nx = d_wdata;
                        // Only grants that made fetch wait count toward the streak.
                        if (f_read && streak != STREAK_MAX) begin
                            streak_nx = streak + STREAK_W'(1);
                        end
                    end
                end
            end
            CMD: begin
                // Acceptance wins over a same-cycle withdrawal.
                if (mem_cack) begin
                    state_nx = WAIT;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                end else if (!owner_req) begin
                    state_nx = IDLE;
                    owner_nx = NONE;
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                end
            end
            WAIT: begin
                if (mem_data_ready) begin
                    state_nx = IDLE;
                    owner_nx = NONE;
                end
            end
            default: begin
                state_nx = IDLE;
                owner_nx = NONE;
                read_nx  = 1'b0;
                write_nx = 1'b0;
            end
        endcase
    end

    // State, owner, streak and registered command outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= NONE;
            streak    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            streak    <= streak_nx;
            mem_read  <= read_nx;
            mem_write <= write_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
        end
    end

    // Handshake responses are steered combinationally to the owner only;
    // pulses arriving in IDLE belong to no one and are dropped.
    assign f_cack       = (state == CMD)  && (owner == FETCH) && mem_cack;
    assign d_cack       = (state == CMD)  && (owner == DATA)  && mem_cack;
    assign f_data_ready = (state == WAIT) && (owner == FETCH) && mem_data_ready;
    assign d_data_ready = (state == WAIT) && (owner == DATA)  && mem_data_ready;
    assign f_data       = (owner == FETCH) ? mem_rdata : '0;
    assign d_data       = (owner == DATA)  ? mem_rdata[15:0] : '0;
    assign f_busy       = mem_busy | ((state != IDLE) && (owner != FETCH));
    assign d_busy       = mem_busy | ((state != IDLE) && (owner != DATA));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single-requester
// transactions plus hand-written contention, starvation, cancel, busy
// and reset sequences. Expected downstream commands are queued when a
// request is driven and popped when the arbiter issues the command.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_read;
    logic [15:0] f_addr;
    logic        f_cack, f_data_ready, f_busy;
    logic [31:0] f_data;
    logic        d_read, d_write;
    logic [15:0] d_addr, d_wdata;
    logic        d_cack, d_data_ready, d_busy;
    logic [15:0] d_data;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_cack, mem_data_ready, mem_busy;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        logic        is_data;
        logic        is_write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [31:0] rdata;
        int          cack_dly;
        int          rdy_dly;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_data;
    } vec_t;

    cmd_t sbq[$];
    vec_t vecs[4];

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .f_read        (f_read),
        .f_addr        (f_addr),
        .f_cack        (f_cack),
        .f_data_ready  (f_data_ready),
        .f_busy        (f_busy),
        .f_data        (f_data),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_cack        (d_cack),
        .d_data_ready  (d_data_ready),
        .d_busy        (d_busy),
        .d_data        (d_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_cack      (mem_cack),
        .mem_data_ready(mem_data_ready),
        .mem_busy      (mem_busy),
        .mem_rdata     (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic cmd_t mk_cmd(input logic rd, input logic wr,
                                    input logic [15:0] addr, input logic [15:0] wdata);
        cmd_t c;
        c.rd    = rd;
        c.wr    = wr;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic fr, input logic [15:0] fa, input logic dr,
                                  input logic dw, input logic [15:0] da, input logic [15:0] dwd);
        f_read  = fr;
        f_addr  = fa;
        d_read  = dr;
        d_write = dw;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // Compare the issued downstream command against the oldest expectation.
    task automatic check_cmd(input string name);
        cmd_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got command with empty scoreboard expected none", name);
        end else begin
            e = sbq.pop_front();
            check_output({name, "_rd"}, mem_read, e.rd);
            check_output({name, "_wr"}, mem_write, e.wr);
            check_word({name, "_addr"}, 32'(mem_addr), 32'(e.addr));
            check_word({name, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
        end
    endtask

    // Advance negedge by negedge until a command appears (bounded).
    task automatic wait_cmd(input string name, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (mem_read || mem_write) break;
        end
        if (!(mem_read || mem_write)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no command expected command within 20 cycles", name);
        end
    endtask

    // Accept the current command, drop requests, deliver read data.
    task automatic complete_txn(input string tag, input logic is_data, input int rdy_dly,
                                input logic [31:0] rdata, input logic [31:0] exp_data);
        mem_cack = 1'b1;
        #1;
        check_output({tag, "_owner_cack"}, is_data ? d_cack : f_cack, 1'b1);
        check_output({tag, "_other_cack"}, is_data ? f_cack : d_cack, 1'b0);
        @(negedge clk);
        mem_cack = 1'b0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check_output({tag, "_cmd_drop"}, mem_read | mem_write, 1'b0);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            #1;
            check_output({tag, "_early_ready"}, is_data ? d_data_ready : f_data_ready, 1'b0);
        end
        @(negedge clk);
        mem_data_ready = 1'b1;
        mem_rdata      = rdata;
        #1;
        check_output({tag, "_owner_ready"}, is_data ? d_data_ready : f_data_ready, 1'b1);
        check_output({tag, "_other_ready"}, is_data ? f_data_ready : d_data_ready, 1'b0);
        check_word({tag, "_owner_data"}, is_data ? 32'(d_data) : f_data, exp_data);
        check_word({tag, "_other_data"}, is_data ? f_data : 32'(d_data), 32'h0);
        @(negedge clk);
        mem_data_ready = 1'b0;
        mem_rdata      = 32'h0;
        #1;
        check_output({tag, "_back_idle"}, f_busy | d_busy, 1'b0);
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int    n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (v.is_data) apply_stimulus(1'b0, 16'h0, !v.is_write, v.is_write, v.addr, v.wdata);
        else           apply_stimulus(1'b1, v.addr, 1'b0, 1'b0, 16'h0, 16'h0);
        sbq.push_back(mk_cmd(v.exp_rd, v.exp_wr, v.addr, v.is_data ? v.wdata : 16'h0));
        wait_cmd({tag, "_wait"}, n);
        check_word({tag, "_latency"}, 32'(n), 32'd1);
        check_cmd({tag, "_cmd"});
        check_output({tag, "_other_busy"}, v.is_data ? f_busy : d_busy, 1'b1);
        check_output({tag, "_owner_busy"}, v.is_data ? d_busy : f_busy, 1'b0);
        for (int i = 0; i < v.cack_dly; i++) begin
            check_output({tag, "_early_cack"}, v.is_data ? d_cack : f_cack, 1'b0);
            @(negedge clk);
            #1;
            check_output({tag, "_cmd_held"}, mem_read | mem_write, 1'b1);
        end
        complete_txn(tag, v.is_data, v.rdy_dly, v.rdata, v.exp_data);
    endtask

    initial begin
        int n;
        rst            = 1'b0;
        mem_cack       = 1'b0;
        mem_data_ready = 1'b0;
        mem_busy       = 1'b0;
        mem_rdata      = 32'h0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Vector table: single-requester transactions with varied latencies.
        vecs[0] = '{is_data: 1'b0, is_write: 1'b0, addr: 16'h0010, wdata: 16'h0,
                    rdata: 32'hDEADBEEF, cack_dly: 2, rdy_dly: 3,
                    exp_rd: 1'b1, exp_wr: 1'b0, exp_data: 32'hDEADBEEF};
        vecs[1] = '{is_data: 1'b1, is_write: 1'b0, addr: 16'h1234, wdata: 16'h0,
                    rdata: 32'h5555AAAA, cack_dly: 0, rdy_dly: 0,
                    exp_rd: 1'b1, exp_wr: 1'b0, exp_data: 32'h0000AAAA};
        vecs[2] = '{is_data: 1'b1, is_write: 1'b1, addr: 16'h0200, wdata: 16'hBEEF,
                    rdata: 32'h0, cack_dly: 1, rdy_dly: 1,
                    exp_rd: 1'b0, exp_wr: 1'b1, exp_data: 32'h0};
        vecs[3] = '{is_data: 1'b0, is_write: 1'b0, addr: 16'hFFFF, wdata: 16'h0,
                    rdata: 32'h01234567, cack_dly: 0, rdy_dly: 2,
                    exp_rd: 1'b1, exp_wr: 1'b0, exp_data: 32'h01234567};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_mem_read", mem_read, 1'b0);
        check_output("rst_mem_write", mem_write, 1'b0);
        check_word("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_output("rst_f_busy", f_busy, 1'b0);
        check_output("rst_d_busy", d_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_vector(i, vecs[i]);
        end

        // Simultaneous fetch and store: data first, fetch after one IDLE cycle.
        @(negedge clk);
        apply_stimulus(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0200, 16'h1234);
        sbq.push_back(mk_cmd(1'b0, 1'b1, 16'h0200, 16'h1234));
        sbq.push_back(mk_cmd(1'b1, 1'b0, 16'h0010, 16'h0));
        wait_cmd("sim_wait_d", n);
        check_word("sim_d_latency", 32'(n), 32'd1);
        check_cmd("sim_d_cmd");
        check_output("sim_f_busy_cmd", f_busy, 1'b1);
        mem_cack = 1'b1;
        #1;
        check_output("sim_d_cack", d_cack, 1'b1);
        check_output("sim_f_cack", f_cack, 1'b0);
        @(negedge clk);
        mem_cack = 1'b0;
        d_write  = 1'b0;
        #1;
        check_output("sim_f_busy_wait", f_busy, 1'b1);
        @(negedge clk);
        mem_data_ready = 1'b1;
        mem_rdata      = 32'h00000042;
        #1;
        check_output("sim_d_ready", d_data_ready, 1'b1);
        check_output("sim_f_ready", f_data_ready, 1'b0);
        check_output("sim_f_busy_done", f_busy, 1'b1);
        @(negedge clk);
        mem_data_ready = 1'b0;
        mem_rdata      = 32'h0;
        #1;
        check_output("sim_idle_gap", mem_read, 1'b0);
        check_output("sim_f_busy_idle", f_busy, 1'b0);
        wait_cmd("sim_wait_f", n);
        check_word("sim_f_latency", 32'(n), 32'd1);
        check_cmd("sim_f_cmd");
        complete_txn("sim_f", 1'b0, 0, 32'hDEADBEEF, 32'hDEADBEEF);

        // Starvation: both held; expect D D D D F D D D D F.
        @(negedge clk);
        apply_stimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0300, 16'h0);
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) sbq.push_back(mk_cmd(1'b1, 1'b0, 16'h0040, 16'h0));
            else                  sbq.push_back(mk_cmd(1'b1, 1'b0, 16'h0300, 16'h0));
        end
        for (int g = 0; g < 10; g++) begin
            wait_cmd($sformatf("starve_wait%0d", g), n);
            check_cmd($sformatf("starve%0d", g));
            mem_cack = 1'b1;
            @(negedge clk);
            mem_cack       = 1'b0;
            mem_data_ready = 1'b1;
            @(negedge clk);
            mem_data_ready = 1'b0;
        end
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Cancel in CMD: data withdraws, pending fetch granted next.
        @(negedge clk);
        apply_stimulus(1'b1, 16'h0050, 1'b1, 1'b0, 16'h0400, 16'h0);
        sbq.push_back(mk_cmd(1'b1, 1'b0, 16'h0400, 16'h0));
        sbq.push_back(mk_cmd(1'b1, 1'b0, 16'h0050, 16'h0));
        wait_cmd("cancel_wait_d", n);
        check_cmd("cancel_d_cmd");
        d_read = 1'b0;
        #1;
        check_output("cancel_no_cack", d_cack, 1'b0);
        @(negedge clk);
        #1;
        check_output("cancel_drop", mem_read, 1'b0);
        check_output("cancel_idle", d_busy, 1'b0);
        wait_cmd("cancel_wait_f", n);
        check_word("cancel_f_latency", 32'(n), 32'd1);
        check_cmd("cancel_f_cmd");
        complete_txn("cancel_f", 1'b0, 0, 32'h13572468, 32'h13572468);

        // Downstream busy holds off both requesters.
        @(negedge clk);
        mem_busy = 1'b1;
        apply_stimulus(1'b1, 16'h0080, 1'b0, 1'b1, 16'h0500, 16'hA5A5);
        sbq.push_back(mk_cmd(1'b0, 1'b1, 16'h0500, 16'hA5A5));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_output("busy_no_cmd", mem_read | mem_write, 1'b0);
            check_output("busy_f_busy", f_busy, 1'b1);
            check_output("busy_d_busy", d_busy, 1'b1);
        end
        mem_busy = 1'b0;
        #1;
        check_output("busy_still_idle", mem_read | mem_write, 1'b0);
        wait_cmd("busy_wait", n);
        check_word("busy_release_latency", 32'(n), 32'd1);
        check_cmd("busy_cmd");

        // Reset during WAIT, then a stale completion pulse.
        mem_cack = 1'b1;
        #1;
        check_output("rstw_d_cack", d_cack, 1'b1);
        @(negedge clk);
        mem_cack  = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        rst = 1'b0;
        #1;
        check_output("rstw_mem_write", mem_write, 1'b0);
        check_word("rstw_mem_addr", 32'(mem_addr), 32'h0);
        check_word("rstw_mem_wdata", 32'(mem_wdata), 32'h0);
        check_word("rstw_d_data", 32'(d_data), 32'h0);
        check_output("rstw_f_busy", f_busy, 1'b0);
        check_output("rstw_d_busy", d_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_data_ready = 1'b1;
        mem_cack       = 1'b1;
        #1;
        check_output("stale_f_ready", f_data_ready, 1'b0);
        check_output("stale_d_ready", d_data_ready, 1'b0);
        check_output("stale_f_cack", f_cack, 1'b0);
        check_output("stale_d_cack", d_cack, 1'b0);
        check_word("stale_f_data", f_data, 32'h0);
        @(negedge clk);
        mem_data_ready = 1'b0;
        mem_cack       = 1'b0;
        mem_rdata      = 32'h0;
        #1;
        check_output("stale_no_cmd", mem_read | mem_write, 1'b0);
        check_word("sb_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
